// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small first-word-fall-through FIFO.
// A single counter times the half-bit start check, the eight data bits and
// the stop bit. Good frames are pushed into the FIFO. A bad stop bit raises
// frame_err, and a good frame that finds the FIFO full raises overflow.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [DIV_W-1:0]           clk_div,
    input  logic                       rx,
    input  logic                       rd_en,
    output logic [7:0]                 rd_data,
    output logic                       rx_valid,
    output logic [$clog2(DEPTH):0]     rx_level,
    output logic                       rx_finish,
    output logic                       frame_err,
    output logic                       overflow,
    input  logic                       err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // Synchronizer and edge detection
    logic rx_meta_reg, rx_s_reg, rx_p_reg;

    // Receiver FSM state
    state_t           state_reg, state_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [2:0]       bit_reg, bit_next;
    logic [7:0]       shift_reg, shift_next;
    logic             stop_done, stop_good;
    logic             finish_reg;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   level_reg, level_next;
    logic          push, pop, full;
    logic          frame_err_reg, overflow_reg;

    logic [DIV_W-1:0] div_eff;
    logic [DIV_W-1:0] half_m1;

    // Divisors below 4 are clamped to 4 so that the half-bit count stays meaningful.
    assign div_eff = (clk_div < DIV_W'(4)) ? DIV_W'(4) : clk_div;
    assign half_m1 = (div_reg >> 1) - DIV_W'(1);

    // Two-flop synchronizer plus the previous synchronized sample. All three idle high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_p_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
            rx_p_reg    <= rx_s_reg;
        end
    end

    // Next-state logic for the receiver. Deasserting en abandons the frame silently.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        div_next   = div_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        stop_done  = 1'b0;
        stop_good  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (en && rx_p_reg && !rx_s_reg) begin
                    state_next = START;
                    cnt_next   = '0;
                    div_next   = div_eff;
                end
            end
            START: begin
                if (cnt_reg == half_m1) begin
                    cnt_next = '0;
                    if (!rx_s_reg) begin
                        state_next = DATA;
                        bit_next   = 3'd0;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + DIV_W'(1);
                end
            end
            DATA: begin
                if (cnt_reg == div_reg - DIV_W'(1)) begin
                    cnt_next   = '0;
                    shift_next = {rx_s_reg, shift_reg[7:1]};
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                    end
                end else begin
                    cnt_next = cnt_reg + DIV_W'(1);
                end
            end
            STOP: begin
                if (cnt_reg == div_reg - DIV_W'(1)) begin
                    cnt_next   = '0;
                    stop_done  = 1'b1;
                    stop_good  = rx_s_reg;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + DIV_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        if (!en) begin
            state_next = IDLE;
            stop_done  = 1'b0;
            stop_good  = 1'b0;
        end
    end

    // Receiver state registers and the one-cycle completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            div_reg    <= DIV_W'(4);
            bit_reg    <= 3'd0;
            shift_reg  <= 8'h00;
            finish_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            div_reg    <= div_next;
            bit_reg    <= bit_next;
            shift_reg  <= shift_next;
            finish_reg <= stop_done;
        end
    end

    // A pop on a full FIFO frees the slot that a simultaneous push needs.
    assign pop  = rd_en && (level_reg != '0);
    assign full = (level_reg == LW'(DEPTH));
    assign push = stop_good && (!full || pop);

    // Occupancy follows the push/pop combination.
    always_comb begin
        level_next = level_reg;
        if (push && !pop) begin
            level_next = level_reg + LW'(1);
        end else if (pop && !push) begin
            level_next = level_reg - LW'(1);
        end
    end

    // FIFO pointers, level and sticky error flags. A set condition wins over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            frame_err_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            level_reg <= level_next;
            if (stop_done && !rx_s_reg) begin
                frame_err_reg <= 1'b1;
            end else if (err_clr) begin
                frame_err_reg <= 1'b0;
            end
            if (stop_good && full && !pop) begin
                overflow_reg <= 1'b1;
            end else if (err_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    // FIFO storage. Contents are not reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= shift_reg;
        end
    end

    assign rd_data   = (level_reg != '0) ? mem[rd_ptr_reg] : 8'h00;
    assign rx_valid  = (level_reg != '0);
    assign rx_level  = level_reg;
    assign rx_finish = finish_reg;
    assign frame_err = frame_err_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo with D=16 and DEPTH=4.
// Inputs are driven on the falling clock edge and outputs are sampled there too.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [15:0] clk_div;
    logic       rx;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [2:0] rx_level;
    logic       rx_finish;
    logic       frame_err;
    logic       overflow;
    logic       err_clr;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int fin_cnt  = 0;
    int fin_cyc  = 0;
    int fall_cyc = 0;
    int meas     = 0;
    int f0       = 0;

    uart_rx_fifo #(.DEPTH(4), .DIV_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clk_div   (clk_div),
        .rx        (rx),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rx_valid  (rx_valid),
        .rx_level  (rx_level),
        .rx_finish (rx_finish),
        .frame_err (frame_err),
        .overflow  (overflow),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Completion pulse monitor: counts pulses and remembers when the last one was seen.
    always @(negedge clk) begin
        if (rx_finish === 1'b1) begin
            fin_cnt <= fin_cnt + 1;
            fin_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One 8N1 frame at 16 clocks per bit. pop_off >= 0 raises rd_en for one
    // clock that many negedges into the stop bit.
    task automatic send(input logic [7:0] b, input logic stop_bit, input int pop_off);
        @(negedge clk);
        rx = 1'b0;
        fall_cyc = cyc;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        rx = stop_bit;
        for (int k = 0; k < 16; k++) begin
            if (k == pop_off) rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check({tag, "_valid"}, 32'(rx_valid), 32'h1);
        check(tag, 32'(rd_data), 32'(exp));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_data"}, 32'(rd_data), 32'h0);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
        check({tag, "_rx_level"}, 32'(rx_level), 32'h0);
        check({tag, "_rx_finish"}, 32'(rx_finish), 32'h0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        check({tag, "_overflow"}, 32'(overflow), 32'h0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; clk_div = 16'd16; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: good 0x0F, latency, pop
        f0 = fin_cnt;
        send(8'h0F, 1'b1, -1);
        check("t1_finish_count", 32'(fin_cnt), 32'(f0 + 1));
        check("t1_data", 32'(rd_data), 32'h0F);
        check("t1_valid", 32'(rx_valid), 32'h1);
        check("t1_level", 32'(rx_level), 32'h1);
        meas = fin_cyc - fall_cyc;
        // Cycles from the first clock edge that samples the low line to the stop-sample edge.
        checks++;
        assert ((meas - 1) >= 152 && (meas - 1) <= 154) else begin
            failures++;
            $error("FAIL t1_latency: observed=%0d expected=152..154", meas - 1);
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("t1_valid_after_pop", 32'(rx_valid), 32'h0);
        check("t1_level_after_pop", 32'(rx_level), 32'h0);

        // 2: short glitch on the line
        f0 = fin_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("t2_no_finish", 32'(fin_cnt), 32'(f0));
        check("t2_valid", 32'(rx_valid), 32'h0);
        check("t2_frame_err", 32'(frame_err), 32'h0);
        check("t2_overflow", 32'(overflow), 32'h0);

        // 3: bad stop bit, clear, then good 0x41
        f0 = fin_cnt;
        send(8'h23, 1'b0, -1);
        check("t3_finish_count", 32'(fin_cnt), 32'(f0 + 1));
        check("t3_frame_err", 32'(frame_err), 32'h1);
        check("t3_level", 32'(rx_level), 32'h0);
        check("t3_overflow", 32'(overflow), 32'h0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t3_frame_err_cleared", 32'(frame_err), 32'h0);
        send(8'h41, 1'b1, -1);
        check("t3_level_good", 32'(rx_level), 32'h1);
        check("t3_frame_err_good", 32'(frame_err), 32'h0);
        pop_check("t3_data_41", 8'h41);

        // 4: five frames into a four-entry FIFO
        for (int v = 1; v <= 5; v++) send(8'(v), 1'b1, -1);
        check("t4_overflow", 32'(overflow), 32'h1);
        check("t4_level", 32'(rx_level), 32'h4);
        pop_check("t4_pop0", 8'h01);
        pop_check("t4_pop1", 8'h02);
        pop_check("t4_pop2", 8'h03);
        pop_check("t4_pop3", 8'h04);
        check("t4_empty", 32'(rx_valid), 32'h0);

        // 5: pop in the same cycle as a push into a full FIFO
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("t5_overflow_cleared", 32'(overflow), 32'h0);
        for (int v = 1; v <= 4; v++) send(8'(v), 1'b1, -1);
        check("t5_full_level", 32'(rx_level), 32'h4);
        f0 = fin_cnt;
        send(8'h55, 1'b1, meas - 145);
        check("t5_finish_count", 32'(fin_cnt), 32'(f0 + 1));
        check("t5_overflow", 32'(overflow), 32'h0);
        check("t5_level", 32'(rx_level), 32'h4);
        pop_check("t5_pop0", 8'h02);
        pop_check("t5_pop1", 8'h03);
        pop_check("t5_pop2", 8'h04);
        pop_check("t5_pop3", 8'h55);

        // 6: asynchronous reset during DATA bit 3 with a non-empty FIFO and a flag set
        send(8'h77, 1'b1, -1);
        send(8'h10, 1'b0, -1);
        check("t6_pre_valid", 32'(rx_valid), 32'h1);
        check("t6_pre_frame_err", 32'(frame_err), 32'h1);
        @(negedge clk);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx = i[0];
            repeat (16) @(negedge clk);
        end
        rx = 1'b1;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("t6_in_reset");
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        f0 = fin_cnt;
        send(8'h3D, 1'b1, -1);
        check("t6_finish_count", 32'(fin_cnt), 32'(f0 + 1));
        check("t6_level", 32'(rx_level), 32'h1);
        check("t6_frame_err", 32'(frame_err), 32'h0);
        check("t6_overflow", 32'(overflow), 32'h0);
        pop_check("t6_data_3d", 8'h3D);
        check("t6_empty", 32'(rx_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
